// File: rtl/simple_sweep_ctrl.sv
// simple_sweep_ctrl: sweeps the 3-input `simple` block through all eight
// input vectors N_PASSES times. Each vector is held for SETTLE_CYCLES clocks.
// The block captures the response into a truth table and compares it against
// an expected table.
// Optional feature: define SIMPLE_SWEEP_ERRCNT_EN to add a saturating
// mismatch counter on output err_cnt.
module simple_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int N_PASSES      = 2,
   parameter int ERR_W         = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] exp_table,
   input  logic       dut_out,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic [7:0] tbl,
   output logic       match
`ifdef SIMPLE_SWEEP_ERRCNT_EN
   ,
   output logic [ERR_W-1:0] err_cnt
`endif
);

   localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int PASS_W = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   state_t              state_next;
   logic [2:0]          idx;
   logic [CNT_W-1:0]    cnt;
   logic [PASS_W-1:0]   pass;
   logic [7:0]          exp_q;
   logic                mismatch;
   logic                start_ok;
   logic                sample;
   logic                last_sample;
   logic                sample_bad;

   // The vector index doubles as the registered stimulus, so a, b and c
   // change on the same edge as the index advances.
   assign {a, b, c} = idx;

   // Decode when a sweep is accepted and when a settled sample is taken.
   // An abort suppresses the sample on that edge.
   always_comb begin
      start_ok    = (state == IDLE) && start && !abort;
      sample      = (state == RUN) && !abort && (cnt == CNT_W'(SETTLE_CYCLES - 1));
      last_sample = sample && (idx == 3'd7) && (pass == PASS_W'(N_PASSES - 1));
      sample_bad  = (dut_out != exp_q[idx]);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and status outputs. DONE always lasts exactly one cycle.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start_ok) state_next = RUN;
         RUN: begin
            busy = 1'b1;
            if (abort)            state_next = IDLE;
            else if (last_sample) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Sweep datapath: settle counter, vector index and pass count, plus the
   // captured table, the sticky mismatch flag and the final verdict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         cnt      <= '0;
         pass     <= '0;
         exp_q    <= '0;
         mismatch <= 1'b0;
         tbl      <= '0;
         match    <= 1'b0;
`ifdef SIMPLE_SWEEP_ERRCNT_EN
         err_cnt  <= '0;
`endif
      end else if (start_ok) begin
         idx      <= '0;
         cnt      <= '0;
         pass     <= '0;
         exp_q    <= exp_table;
         mismatch <= 1'b0;
         match    <= 1'b0;
`ifdef SIMPLE_SWEEP_ERRCNT_EN
         err_cnt  <= '0;
`endif
      end else if (state == RUN) begin
         if (abort) begin
            idx   <= '0;
            cnt   <= '0;
            pass  <= '0;
            match <= 1'b0;
         end else if (sample) begin
            tbl[idx] <= dut_out;
            mismatch <= mismatch | sample_bad;
            cnt      <= '0;
            idx      <= idx + 3'd1;
            if (last_sample) begin
               pass  <= '0;
               match <= ~(mismatch | sample_bad);
            end else if (idx == 3'd7) begin
               pass <= pass + 1'b1;
            end
`ifdef SIMPLE_SWEEP_ERRCNT_EN
            if (sample_bad && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
`endif
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_simple_sweep_ctrl.sv
// Testbench for simple_sweep_ctrl. The `simple` block is modelled as a truth
// table. Expected results come from the sweep rules: the vector index at a
// given cycle, the done time, the table contents, the verdict and the error
// count.
module tb_simple_sweep_ctrl;

   localparam int S     = 2;
   localparam int NP    = 2;
   localparam int ERR_W = 5;
   localparam int TOTAL = 8 * NP * S;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] exp_table;
   logic       dut_out;
   logic       a, b, c, busy, done, match;
   logic [7:0] tbl;
   logic [7:0] dut_tt;
`ifdef SIMPLE_SWEEP_ERRCNT_EN
   logic [ERR_W-1:0] err_cnt;
   logic [ERR_W-1:0] err_cnt2;
`endif

   // Second instance for the shortest configuration, with the DUT tied high.
   logic       start2;
   logic       a2, b2, c2, busy2, done2, match2;
   logic [7:0] tbl2;

   int checks = 0;
   int errors = 0;
   logic [7:0] model_tbl = 8'h00;

   always #5 clk = ~clk;

   assign dut_out = dut_tt[{a, b, c}];

   simple_sweep_ctrl #(.SETTLE_CYCLES(S), .N_PASSES(NP), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .exp_table(exp_table), .dut_out(dut_out),
      .a(a), .b(b), .c(c), .busy(busy), .done(done), .tbl(tbl), .match(match)
`ifdef SIMPLE_SWEEP_ERRCNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   simple_sweep_ctrl #(.SETTLE_CYCLES(1), .N_PASSES(1), .ERR_W(ERR_W)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
      .exp_table(8'hFF), .dut_out(1'b1),
      .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .tbl(tbl2), .match(match2)
`ifdef SIMPLE_SWEEP_ERRCNT_EN
      , .err_cnt(err_cnt2)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int popcount8(input logic [7:0] v);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(v[i]);
      return n;
   endfunction

   // One sweep on the main instance. An abort, a stray start or a reset can be
   // injected at cycle k after the accepting edge; pass -1 to disable each one.
   task automatic applyStimulus(input logic [7:0] tt, input logic [7:0] expt,
                                input int abort_at, input int restart_at, input int reset_at);
      int n;
      int errs;
      logic [7:0] partial;
      dut_tt    = tt;
      @(negedge clk);
      exp_table = expt;
      start     = 1'b1;
      abort     = 1'b0;
      @(negedge clk);
      start     = 1'b0;
      for (int k = 0; k <= TOTAL + 1; k++) begin
         if (k == reset_at) begin
            rst_n = 1'b0;
            #1;
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_tbl", tbl, 0);
            checkOutput("rst_match", match, 0);
            checkOutput("rst_abc", {a, b, c}, 0);
            #1 rst_n = 1'b1;
            model_tbl = 8'h00;
            @(negedge clk);
            return;
         end
         if (abort_at >= 0 && k == abort_at + 1) begin
            n = abort_at / S;
            partial = model_tbl;
            for (int j = 0; j < n; j++) partial[j % 8] = tt[j % 8];
            model_tbl = partial;
            abort = 1'b0;
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_done", done, 0);
            checkOutput("abort_match", match, 0);
            checkOutput("abort_abc", {a, b, c}, 0);
            checkOutput("abort_tbl", tbl, partial);
            @(negedge clk);
            checkOutput("abort_nodone", done, 0);
            return;
         end
         if (k < TOTAL) begin
            checkOutput("run_busy", busy, 1);
            checkOutput("run_done", done, 0);
            checkOutput("run_abc", {a, b, c}, (k / S) % 8);
         end else if (k == TOTAL) begin
            model_tbl = tt;
            checkOutput("end_done", done, 1);
            checkOutput("end_busy", busy, 0);
            checkOutput("end_tbl", tbl, tt);
            checkOutput("end_match", match, (tt == expt) ? 1 : 0);
            checkOutput("end_abc", {a, b, c}, 0);
`ifdef SIMPLE_SWEEP_ERRCNT_EN
            errs = popcount8(tt ^ expt) * NP;
            if (errs > (1 << ERR_W) - 1) errs = (1 << ERR_W) - 1;
            checkOutput("end_errcnt", err_cnt, errs);
`endif
         end else begin
            checkOutput("post_done", done, 0);
            checkOutput("post_match", match, (tt == expt) ? 1 : 0);
            checkOutput("post_tbl", tbl, tt);
         end
         start = (k == restart_at);
         abort = (k == abort_at);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      int k2;
      logic [7:0] tt;
      logic [7:0] ex;
      int ab;
      rst_n     = 1'b0;
      start     = 1'b0;
      start2    = 1'b0;
      abort     = 1'b0;
      exp_table = 8'h00;
      dut_tt    = 8'hE8;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_tbl", tbl, 0);
      checkOutput("reset_match", match, 0);
      checkOutput("reset_abc", {a, b, c}, 0);
      rst_n = 1'b1;

      // Majority function, with a matching and then a non-matching expectation.
      applyStimulus(8'hE8, 8'hE8, -1, -1, -1);
      applyStimulus(8'hE8, 8'hE9, -1, -1, -1);
      // Abort at 10 clocks into the sweep.
      applyStimulus(8'hE8, 8'hE8, 10, -1, -1);
      // A stray start at clock 5 must be ignored.
      applyStimulus(8'hE8, 8'hE8, -1, 5, -1);
      // Reset in mid-sweep, then a fresh sweep.
      applyStimulus(8'hE8, 8'hE8, -1, -1, 7);
      applyStimulus(8'hE8, 8'hE8, -1, -1, -1);

      // Shortest configuration: done is expected 8 clocks after the accepting edge.
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      k2 = 0;
      while (!done2 && k2 < 20) begin
         @(negedge clk);
         k2++;
      end
      checkOutput("short_latency", k2, 8);
      checkOutput("short_tbl", tbl2, 8'hFF);
      checkOutput("short_match", match2, 1);

      // Randomized sweeps.
      for (int i = 0; i < 12; i++) begin
         tt = 8'($urandom);
         ex = ($urandom_range(0, 1) == 1) ? tt : 8'($urandom);
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TOTAL - 2)) : -1;
         applyStimulus(tt, ex, ab, int'($urandom_range(1, TOTAL - 2)), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
